// File: rtl/consmax_pkg.sv
// Shared definitions for the ConSmax pack stage: default widths, the packed
// word layout carried through the output FIFO, and the FIFO depth.
// Optional row-sum feature: CONSMAX_PACK_ROWSUM_EN.
package consmax_pkg;

  localparam int DEF_IDATA_BIT = 8;
  localparam int DEF_CDATA_BIT = 8;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_SUM_BIT   = DEF_IDATA_BIT + DEF_CDATA_BIT;
  localparam int FIFO_DEPTH    = 2;

`ifdef CONSMAX_PACK_ROWSUM_EN
  localparam bit ROWSUM_EN = 1'b1;
`else
  localparam bit ROWSUM_EN = 1'b0;
`endif

  // One output word at the default widths; sum sits above data, last in the LSB.
  typedef struct packed {
`ifdef CONSMAX_PACK_ROWSUM_EN
    logic [DEF_SUM_BIT-1:0]               sum;
`endif
    logic [DEF_NUM_LANES*DEF_IDATA_BIT-1:0] data;
    logic [DEF_NUM_LANES-1:0]               mask;
    logic                                   last;
  } word_t;

  // Flat FIFO entry width for an arbitrary parameterisation.
  function automatic int entry_bits(input int idata_bit, input int num_lanes,
                                    input int sum_bit, input bit rowsum_en);
    return idata_bit * num_lanes + num_lanes + 1 + (rowsum_en ? sum_bit : 0);
  endfunction

endpackage

// File: rtl/consmax_pack_if.sv
// Output word stream of the ConSmax pack stage towards the score x V matmul.
// The row_sum signal exists only when CONSMAX_PACK_ROWSUM_EN is defined.
interface consmax_pack_if
  import consmax_pkg::*;
#(
  parameter int IDATA_BIT = DEF_IDATA_BIT,
  parameter int NUM_LANES = DEF_NUM_LANES
`ifdef CONSMAX_PACK_ROWSUM_EN
  ,
  parameter int SUM_BIT   = DEF_SUM_BIT
`endif
) ();

  logic [NUM_LANES*IDATA_BIT-1:0] odata;
  logic [NUM_LANES-1:0]           odata_mask;
  logic                           odata_last;
  logic                           odata_valid;
  logic                           odata_ready;
`ifdef CONSMAX_PACK_ROWSUM_EN
  logic [SUM_BIT-1:0]             row_sum;
`endif

  modport master (
    output odata, odata_mask, odata_last, odata_valid,
`ifdef CONSMAX_PACK_ROWSUM_EN
    output row_sum,
`endif
    input  odata_ready
  );

  modport slave (
    input  odata, odata_mask, odata_last, odata_valid,
`ifdef CONSMAX_PACK_ROWSUM_EN
    input  row_sum,
`endif
    output odata_ready
  );

endinterface

// File: rtl/consmax_pack_fifo.sv
// Two-entry valid/ready word FIFO. A push into a full FIFO is accepted only
// when the head is popped in the same cycle; otherwise it is dropped and the
// drop strobe is raised for that cycle.
module consmax_pack_fifo
  import consmax_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             drop
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             pop;
  logic             accept;

  // Handshake decode: pop on valid&&ready, push accepted if room or popping.
  always_comb begin
    head_valid = (count != 2'd0);
    pop        = head_valid && ready;
    accept     = push && ((count != 2'(FIFO_DEPTH)) || pop);
    drop       = push && !accept;
    head_data  = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/consmax_pack.sv
// ConSmax pack stage: gathers the serial INT8 exp-score stream into
// NUM_LANES-wide words, tags row ends and buffers words in a 2-entry FIFO.
// Optional macro CONSMAX_PACK_ROWSUM_EN adds a per-row signed sum output.
module consmax_pack
  import consmax_pkg::*;
#(
  parameter int IDATA_BIT = DEF_IDATA_BIT,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CDATA_BIT = DEF_CDATA_BIT,
  parameter int SUM_BIT   = IDATA_BIT + CDATA_BIT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CDATA_BIT-1:0] cfg_row_len,
  input  logic                 cfg_clr,
  input  logic [IDATA_BIT-1:0] idata,
  input  logic                 idata_valid,
  consmax_pack_if.master       obus,
  output logic                 err_overflow
);

  localparam int LANE_W  = $clog2(NUM_LANES);
  localparam int DATA_W  = NUM_LANES * IDATA_BIT;
  localparam int ENTRY_W = entry_bits(IDATA_BIT, NUM_LANES, SUM_BIT, ROWSUM_EN);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  logic [LANE_W-1:0]    lane_cnt;
  logic [CDATA_BIT-1:0] elem_cnt;
  logic [CDATA_BIT-1:0] row_len_q;
  logic [DATA_W-1:0]    asm_data;
  logic [NUM_LANES-1:0] asm_mask;

  logic [CDATA_BIT-1:0] cfg_len_eff;
  logic [CDATA_BIT-1:0] cur_len;
  logic                 row_last;
  logic                 word_done;
  logic [DATA_W-1:0]    word_data;
  logic [NUM_LANES-1:0] word_mask;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic [ENTRY_W-1:0]   head_gated;
  logic                 head_valid;
  logic                 drop;

  // Row-end detection (first element of a row uses the live config) and
  // the assembly word with the incoming element merged into its lane.
  always_comb begin
    cfg_len_eff = (cfg_row_len == '0) ? CDATA_BIT'(1) : cfg_row_len;
    cur_len     = (elem_cnt == '0) ? cfg_len_eff : row_len_q;
    row_last    = (elem_cnt == cur_len - CDATA_BIT'(1));
    word_done   = idata_valid && ((lane_cnt == LAST_LANE) || row_last);
    word_data   = asm_data;
    word_mask   = asm_mask;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_cnt == LANE_W'(i)) begin
        word_data[i*IDATA_BIT +: IDATA_BIT] = idata;
        word_mask[i] = 1'b1;
      end
    end
  end

  // Lane/element counters and the partial-word assembly register.
  always_ff @(posedge clk) begin
    if (!rstn || cfg_clr) begin
      lane_cnt  <= '0;
      elem_cnt  <= '0;
      row_len_q <= '0;
      asm_data  <= '0;
      asm_mask  <= '0;
    end else if (idata_valid) begin
      if (elem_cnt == '0) row_len_q <= cfg_len_eff;
      if (word_done) begin
        lane_cnt <= '0;
        asm_data <= '0;
        asm_mask <= '0;
        elem_cnt <= row_last ? '0 : elem_cnt + CDATA_BIT'(1);
      end else begin
        lane_cnt <= lane_cnt + LANE_W'(1);
        asm_data <= word_data;
        asm_mask <= word_mask;
        elem_cnt <= elem_cnt + CDATA_BIT'(1);
      end
    end
  end

`ifdef CONSMAX_PACK_ROWSUM_EN
  logic [SUM_BIT-1:0] sum_acc;
  logic [SUM_BIT-1:0] sum_next;
  logic [SUM_BIT-1:0] idata_sext;

  // Running signed row sum restarting at the first element of each row.
  always_comb begin
    idata_sext = {{(SUM_BIT-IDATA_BIT){idata[IDATA_BIT-1]}}, idata};
    sum_next   = (elem_cnt == '0) ? idata_sext : sum_acc + idata_sext;
    push_entry = {(row_last ? sum_next : '0), word_data, word_mask, row_last};
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rstn || cfg_clr) sum_acc <= '0;
    else if (idata_valid) sum_acc <= sum_next;
  end
`else
  // FIFO entry: data above mask above the last flag.
  always_comb begin
    push_entry = {word_data, word_mask, row_last};
  end
`endif

  consmax_pack_fifo #(.WIDTH(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (cfg_clr),
    .push       (word_done),
    .push_data  (push_entry),
    .ready      (obus.odata_ready),
    .head_data  (head_entry),
    .head_valid (head_valid),
    .drop       (drop)
  );

  // Sticky overflow flag set whenever a completed word could not be stored.
  always_ff @(posedge clk) begin
    if (!rstn || cfg_clr) err_overflow <= 1'b0;
    else if (drop)        err_overflow <= 1'b1;
  end

  assign head_gated       = head_valid ? head_entry : '0;
  assign obus.odata_valid = head_valid;
  assign obus.odata_last  = head_gated[0];
  assign obus.odata_mask  = head_gated[NUM_LANES:1];
  assign obus.odata       = head_gated[NUM_LANES+DATA_W:NUM_LANES+1];
`ifdef CONSMAX_PACK_ROWSUM_EN
  assign obus.row_sum     = head_gated[ENTRY_W-1 -: SUM_BIT];
`endif

endmodule

// File: tb/tb_consmax_pack.sv
// Self-checking bench for consmax_pack: a queue-based model of the word
// stream and FIFO is compared every cycle, plus literal per-test expectations.
// Row-sum checks are built only when CONSMAX_PACK_ROWSUM_EN is defined.
module tb_consmax_pack;
  import consmax_pkg::*;

  localparam int NL = DEF_NUM_LANES;

  logic       clk;
  logic       rstn;
  logic [7:0] cfg_row_len;
  logic       cfg_clr;
  logic [7:0] idata;
  logic       idata_valid;
  logic       err_overflow;
  bit         chk_en;
  int         n_checks;
  int         n_errors;

  consmax_pack_if obus_if ();

  consmax_pack dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_row_len  (cfg_row_len),
    .cfg_clr      (cfg_clr),
    .idata        (idata),
    .idata_valid  (idata_valid),
    .obus         (obus_if),
    .err_overflow (err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: words waiting in a capacity-2 queue, elements of the
  // word being gathered, position within the row and the row sum.
  word_t      mq[$];
  logic [7:0] cur[$];
  int         m_pos;
  int         m_len;
  int         m_sum;
  bit         m_err;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model update on each active edge using the same inputs the DUT sees.
  always @(posedge clk) begin : model_proc
    word_t w;
    bit    popd;
    bit    done;
    if (!rstn || cfg_clr) begin
      mq.delete();
      cur.delete();
      m_pos = 0;
      m_sum = 0;
      m_err = 0;
    end else begin
      popd = (mq.size() != 0) && obus_if.odata_ready;
      done = 0;
      w    = '0;
      if (idata_valid) begin
        if (m_pos == 0) begin
          m_len = (cfg_row_len == 0) ? 1 : int'(cfg_row_len);
          m_sum = $signed(idata);
        end else begin
          m_sum = m_sum + $signed(idata);
        end
        cur.push_back(idata);
        m_pos++;
        if (cur.size() == NL || m_pos == m_len) begin
          for (int i = 0; i < cur.size(); i++) begin
            w.data[i*8 +: 8] = cur[i];
            w.mask[i]        = 1'b1;
          end
          w.last = (m_pos == m_len);
`ifdef CONSMAX_PACK_ROWSUM_EN
          w.sum = w.last ? 16'(m_sum) : 16'd0;
`endif
          done = 1;
          cur.delete();
          if (m_pos == m_len) m_pos = 0;
        end
      end
      if (popd) void'(mq.pop_front());
      if (done) begin
        if (mq.size() < 2) mq.push_back(w);
        else m_err = 1;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model head.
  always @(negedge clk) begin : cmp_proc
    word_t ew;
    bit    ev;
    if (chk_en) begin
      ev = (mq.size() != 0);
      ew = '0;
      if (ev) ew = mq[0];
      cmp("model_valid", 64'(obus_if.odata_valid), 64'(ev));
      cmp("model_data",  64'(obus_if.odata),       64'(ew.data));
      cmp("model_mask",  64'(obus_if.odata_mask),  64'(ew.mask));
      cmp("model_last",  64'(obus_if.odata_last),  64'(ew.last));
      cmp("model_err",   64'(err_overflow),        64'(m_err));
`ifdef CONSMAX_PACK_ROWSUM_EN
      cmp("model_sum",   64'(obus_if.row_sum),     64'(ew.sum));
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    idata_valid         = v;
    idata               = d;
    obus_if.odata_ready = r;
  endtask

  task automatic pulseReset(input bit use_clr);
    @(negedge clk);
    idata_valid = 1'b0;
    if (use_clr) cfg_clr = 1'b1;
    else         rstn    = 1'b0;
    @(negedge clk);
    cfg_clr = 1'b0;
    rstn    = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [31:0] ed,
                             input logic [3:0] em, input logic el, input logic ee);
    cmp({name, "_valid"}, 64'(obus_if.odata_valid), 64'(ev));
    cmp({name, "_data"},  64'(obus_if.odata),       64'(ed));
    cmp({name, "_mask"},  64'(obus_if.odata_mask),  64'(em));
    cmp({name, "_last"},  64'(obus_if.odata_last),  64'(el));
    cmp({name, "_err"},   64'(err_overflow),        64'(ee));
  endtask

  initial begin
    rstn = 1'b0; cfg_clr = 1'b0; cfg_row_len = 8'd8;
    idata = 8'd0; idata_valid = 1'b0; obus_if.odata_ready = 1'b0;
    chk_en = 0; n_checks = 0; n_errors = 0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    checkOutput("reset", 0, 32'h0, 4'h0, 0, 0);
    rstn = 1'b1;

    $display("[TB] test 1: row of 8");
    cfg_row_len = 8'd8;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1, 8'(e), 1);
      if (e == 4) checkOutput("t1_pre", 0, 32'h0, 4'h0, 0, 0);
      if (e == 5) checkOutput("t1_w0", 1, 32'h04030201, 4'hF, 0, 0);
    end
    applyStimulus(0, 8'd0, 1); checkOutput("t1_w1", 1, 32'h08070605, 4'hF, 1, 0);
    applyStimulus(0, 8'd0, 1); checkOutput("t1_empty", 0, 32'h0, 4'h0, 0, 0);

    $display("[TB] test 2: row of 6, partial word");
    cfg_row_len = 8'd6;
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1, 8'(e), 1);
      if (e == 5) checkOutput("t2_w0", 1, 32'h04030201, 4'hF, 0, 0);
    end
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1, 8'(8'h20 + e), 1);
      if (e == 1) checkOutput("t2_w1", 1, 32'h00000605, 4'b0011, 1, 0);
      if (e == 5) checkOutput("t2_next_w0", 1, 32'h24232221, 4'hF, 0, 0);
    end
    applyStimulus(0, 8'd0, 1); checkOutput("t2_next_w1", 1, 32'h00002625, 4'b0011, 1, 0);
    applyStimulus(0, 8'd0, 1);

    $display("[TB] test 3: overflow drop");
    cfg_row_len = 8'd16;
    for (int e = 1; e <= 16; e++) begin
      applyStimulus(1, 8'(e), (e >= 13) ? 1'b1 : 1'b0);
      if (e == 13) checkOutput("t3_w1", 1, 32'h04030201, 4'hF, 0, 1);
      if (e == 14) checkOutput("t3_w2", 1, 32'h08070605, 4'hF, 0, 1);
      if (e == 15) checkOutput("t3_gap", 0, 32'h0, 4'h0, 0, 1);
    end
    applyStimulus(0, 8'd0, 1); checkOutput("t3_w4", 1, 32'h100F0E0D, 4'hF, 1, 1);
    applyStimulus(0, 8'd0, 1); checkOutput("t3_empty", 0, 32'h0, 4'h0, 0, 1);
    pulseReset(1); checkOutput("t3_clr", 0, 32'h0, 4'h0, 0, 0);

    $display("[TB] test 4: full FIFO with same-cycle pop");
    cfg_row_len = 8'd12;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1, 8'(e), (e == 12) ? 1'b1 : 1'b0);
      if (e == 12) checkOutput("t4_full", 1, 32'h04030201, 4'hF, 0, 0);
    end
    applyStimulus(0, 8'd0, 1); checkOutput("t4_w2", 1, 32'h08070605, 4'hF, 0, 0);
    applyStimulus(0, 8'd0, 1); checkOutput("t4_w3", 1, 32'h0C0B0A09, 4'hF, 1, 0);
    applyStimulus(0, 8'd0, 1); checkOutput("t4_empty", 0, 32'h0, 4'h0, 0, 0);

    $display("[TB] test 5: mid-row reset and clear");
    for (int k = 0; k < 2; k++) begin
      cfg_row_len = 8'd8;
      for (int e = 1; e <= 5; e++) applyStimulus(1, 8'(e), 0);
      applyStimulus(0, 8'd0, 0); checkOutput("t5_pre", 1, 32'h04030201, 4'hF, 0, 0);
      pulseReset(k == 1); checkOutput("t5_abort", 0, 32'h0, 4'h0, 0, 0);
      for (int e = 1; e <= 8; e++) begin
        applyStimulus(1, 8'(8'h30 + e), 1);
        if (e == 5) checkOutput("t5_w0", 1, 32'h34333231, 4'hF, 0, 0);
      end
      applyStimulus(0, 8'd0, 1); checkOutput("t5_w1", 1, 32'h38373635, 4'hF, 1, 0);
      applyStimulus(0, 8'd0, 1);
    end

    $display("[TB] test 7: row length 0 behaves as 1");
    cfg_row_len = 8'd0;
    applyStimulus(1, 8'h55, 1);
    applyStimulus(1, 8'h66, 1); checkOutput("t7_a", 1, 32'h00000055, 4'b0001, 1, 0);
    applyStimulus(0, 8'd0, 1);  checkOutput("t7_b", 1, 32'h00000066, 4'b0001, 1, 0);
    applyStimulus(0, 8'd0, 1);

`ifdef CONSMAX_PACK_ROWSUM_EN
    $display("[TB] test 6: row sum");
    cfg_row_len = 8'd5;
    applyStimulus(1, 8'h7F, 1);
    applyStimulus(1, 8'h7F, 1);
    applyStimulus(1, 8'h80, 1);
    applyStimulus(1, 8'hFF, 1);
    applyStimulus(1, 8'h0A, 1);
    checkOutput("t6_w0", 1, 32'hFF807F7F, 4'hF, 0, 0);
    cmp("t6_sum_w0", 64'(obus_if.row_sum), 64'd0);
    applyStimulus(0, 8'd0, 1);
    checkOutput("t6_w1", 1, 32'h0000000A, 4'b0001, 1, 0);
    cmp("t6_sum_w1", 64'(obus_if.row_sum), 64'd135);
    applyStimulus(0, 8'd0, 1);
`endif

    applyStimulus(0, 8'd0, 0);
    applyStimulus(0, 8'd0, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
